// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter #(
  parameter int DSIZE = 8,
  parameter int NREQ = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);
  localparam int PW = $clog2(NREQ);
  localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [PW-1:0] ptr, g, g_next, scan, win;
  logic [BW-1:0] beats;
  logic own_valid, rel, found;
  assign busy = state == GRANT;
  always_comb begin
    g = '0;
    for (int i = 0; i < NREQ; i++) g = grant[i] ? PW'(i) : g;
  end
  assign own_valid = busy & |(req_valid & grant);
  assign winc = own_valid & ~wfull;
  assign req_ready = (busy & ~wfull) ? grant : '0;
  assign wdata = busy ? req_data[int'(g)*DSIZE +: DSIZE] : '0;
  assign rel = busy & (~own_valid | (winc & (req_last[g] | beats == BW'(MAX_BURST-1))));
  assign g_next = (int'(g) == NREQ-1) ? '0 : g + 1'b1;
  assign scan = rel ? g_next : ptr;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      win = req_valid[(int'(scan)+k) % NREQ] ? PW'((int'(scan)+k) % NREQ) : win;
      found = found | req_valid[(int'(scan)+k) % NREQ];
    end
  end
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr <= '0;
      beats <= '0;
    end else begin
      if (rel) ptr <= g_next;
      if (!busy || rel) begin
        state <= found ? GRANT : IDLE;
        grant <= found ? NREQ'(1) << win : '0;
        beats <= '0;
      end else if (winc) begin
        beats <= beats + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven cycle checks plus FIFO write-stream scoreboard
module tb_fifo_wr_arbiter;
  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       f;
    logic [3:0] g;
    logic       w;
  } row_t;
  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  logic [3:0] req_valid, req_last, req_ready, grant, acc;
  logic [31:0] req_data;
  logic wfull, winc, busy;
  logic [7:0] wdata;
  logic [5:0] cnt [4];
  logic [5:0] exp_cnt [4];
  logic [7:0] sb [$];
  row_t rows [$];
  int checks = 0;
  int errors = 0;
  always #5 wclk = ~wclk;
  fifo_wr_arbiter #(.DSIZE(8), .NREQ(4), .MAX_BURST(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .grant(grant), .busy(busy)
  );
  function automatic int idx(input logic [3:0] o);
    int r = 0;
    for (int i = 0; i < 4; i++) if (o[i]) r = i;
    return r;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask
  task automatic add(input int n, input logic [3:0] v, input logic [3:0] l, input logic f,
                     input logic [3:0] g, input logic w);
    row_t r;
    r.v = v; r.l = l; r.f = f; r.g = g; r.w = w;
    repeat (n) rows.push_back(r);
  endtask
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f);
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) cnt[i] = cnt[i] + 6'd1;
      req_data[i*8 +: 8] = {2'(i), cnt[i]};
    end
    acc = '0;
    req_valid = v;
    req_last = l;
    wfull = f;
  endtask
  task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic [3:0] eg, input logic ew);
    int o;
    @(posedge wclk);
    #1;
    drive(v, l, f);
    @(negedge wclk);
    o = idx(eg);
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(eg != 4'b0));
    chk("winc", 32'(winc), 32'(ew));
    chk("req_ready", 32'(req_ready), (eg != 4'b0 && !f) ? 32'(eg) : 32'd0);
    if (ew) begin
      sb.push_back({2'(o), exp_cnt[o]});
      exp_cnt[o] = exp_cnt[o] + 6'd1;
    end
    if (winc) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wdata_extra at %0t: got beat %0h expected none", $time, wdata);
      end else begin
        chk("wdata", 32'(wdata), 32'(sb.pop_front()));
      end
    end else if (!busy) begin
      chk("wdata_idle", 32'(wdata), 32'd0);
    end
    acc = req_valid & req_ready;
  endtask
  initial begin
    req_valid = '0; req_last = '0; wfull = 1'b0; req_data = '0; acc = '0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = '0;
      exp_cnt[i] = '0;
    end
    repeat (2) @(negedge wclk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_winc", 32'(winc), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    wrst_n = 1'b1;
    add(1, 4'b0001, 4'b0000, 0, 4'b0000, 0);
    add(2, 4'b0001, 4'b0000, 0, 4'b0001, 1);
    add(1, 4'b0001, 4'b0001, 0, 4'b0001, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0001, 0);
    add(1, 4'b1111, 4'b0000, 0, 4'b0000, 0);
    add(4, 4'b1111, 4'b0000, 0, 4'b0010, 1);
    add(4, 4'b1111, 4'b0000, 0, 4'b0100, 1);
    add(4, 4'b1111, 4'b0000, 0, 4'b1000, 1);
    add(4, 4'b1111, 4'b0000, 0, 4'b0001, 1);
    add(4, 4'b1111, 4'b0000, 0, 4'b0010, 1);
    add(2, 4'b1111, 4'b0000, 0, 4'b0100, 1);
    add(5, 4'b1111, 4'b0000, 1, 4'b0100, 0);
    add(2, 4'b1111, 4'b0000, 0, 4'b0100, 1);
    add(1, 4'b0010, 4'b0000, 0, 4'b1000, 0);
    add(1, 4'b1011, 4'b0000, 0, 4'b0010, 1);
    add(1, 4'b1001, 4'b0000, 0, 4'b0010, 0);
    add(1, 4'b1001, 4'b1000, 0, 4'b1000, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0001, 0);
    add(1, 4'b0010, 4'b0000, 0, 4'b0000, 0);
    add(1, 4'b0000, 4'b0000, 0, 4'b0010, 0);
    add(1, 4'b0110, 4'b0000, 0, 4'b0000, 0);
    add(1, 4'b0110, 4'b0100, 0, 4'b0100, 1);
    add(1, 4'b0010, 4'b0010, 0, 4'b0010, 1);
    add(1, 4'b0000, 4'b0000, 0, 4'b0010, 0);
    add(1, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    foreach (rows[r]) cycle(rows[r].v, rows[r].l, rows[r].f, rows[r].g, rows[r].w);
    chk("sb_drain_table", 32'(sb.size()), 32'd0);
    cycle(4'b0001, 4'b0000, 0, 4'b0000, 0);
    cycle(4'b0001, 4'b0000, 0, 4'b0001, 1);
    @(posedge wclk);
    #1;
    drive(4'b0001, 4'b0000, 0);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("arst_winc", 32'(winc), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wdata", 32'(wdata), 32'd0);
    req_valid = '0;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = '0;
      exp_cnt[i] = '0;
    end
    @(negedge wclk);
    wrst_n = 1'b1;
    cycle(4'b1111, 4'b0000, 0, 4'b0000, 0);
    cycle(4'b1111, 4'b0000, 0, 4'b0001, 1);
    cycle(4'b0000, 4'b0000, 0, 4'b0001, 0);
    cycle(4'b0000, 4'b0000, 0, 4'b0000, 0);
    chk("sb_drain_final", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
